// File: rtl/add_pkg.sv
// rtl/add_pkg.sv - shared types and sizing helpers for the digit-serial adder
package add_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int steps(input int width, input int digit);
      return width / digit;
   endfunction

   // Step counter never collapses to zero bits, even for a single-step config
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/add_digit.sv
// rtl/add_digit.sv - combinational DIGIT-bit ripple of full-adder cells
module add_digit #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] a_d,
   input  logic [DIGIT-1:0] b_d,
   input  logic             c_in,
   output logic [DIGIT-1:0] s_d,
   output logic             c_out,
   output logic             c_msb_in
);

   logic [DIGIT:0] c;

   always_comb begin
      c    = '0;
      s_d  = '0;
      c[0] = c_in;
      for (int i = 0; i < DIGIT; i++) begin
         s_d[i]  = a_d[i] ^ b_d[i] ^ c[i];
         c[i+1]  = (a_d[i] & b_d[i]) | (c[i] & (a_d[i] ^ b_d[i]));
      end
      c_out    = c[DIGIT];
      c_msb_in = c[DIGIT-1];
   end

endmodule

// File: rtl/add_serial_n.sv
// rtl/add_serial_n.sv - multi-cycle adder/subtractor, DIGIT bits per clock, valid/ready handshake
module add_serial_n
   import add_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int STEPS = steps(WIDTH, DIGIT);
   localparam int CW    = cnt_width(STEPS);
   localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

   generate
      if (WIDTH < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
         $fatal(1, "add_serial_n: WIDTH must be >= 1 and a multiple of DIGIT");
      end
   endgenerate

   state_t           state, state_nxt;
   logic [WIDTH-1:0] op_a, op_b, sum_r;
   logic             carry, cout_r, ovf_r;
   logic [CW-1:0]    step;
   logic [DIGIT-1:0] s_d;
   logic             c_out, c_msb_in;
   logic [WIDTH+DIGIT-1:0] sum_cat;

   // Operands shift right each step so the active digit is always bits [DIGIT-1:0]
   add_digit #(.DIGIT(DIGIT)) u_digit (
      .a_d      (op_a[DIGIT-1:0]),
      .b_d      (op_b[DIGIT-1:0]),
      .c_in     (carry),
      .s_d      (s_d),
      .c_out    (c_out),
      .c_msb_in (c_msb_in)
   );

   assign sum_cat = {s_d, sum_r};

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = RUN;
         end
         RUN: begin
            if (step == LAST) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         op_a   <= '0;
         op_b   <= '0;
         sum_r  <= '0;
         carry  <= 1'b0;
         cout_r <= 1'b0;
         ovf_r  <= 1'b0;
         step   <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  op_a  <= a;
                  op_b  <= b ^ {WIDTH{sub}};
                  carry <= sub | cin;
                  step  <= '0;
               end
            end
            RUN: begin
               // Result digits enter at the top; after STEPS shifts sum_r is complete
               op_a  <= op_a >> DIGIT;
               op_b  <= op_b >> DIGIT;
               sum_r <= sum_cat[WIDTH+DIGIT-1:DIGIT];
               carry <= c_out;
               step  <= step + 1'b1;
               if (step == LAST) begin
                  cout_r <= c_out;
                  ovf_r  <= c_out ^ c_msb_in;
               end
            end
            default: ;
         endcase
      end
   end

   assign sum  = sum_r;
   assign cout = cout_r;
   assign ovf  = ovf_r;

endmodule

// File: tb/tb_add_serial_n.sv
// tb/tb_add_serial_n.sv - randomized self-checking bench, DIGIT=4 and DIGIT=16 instances
module tb_add_serial_n;

   logic        clk = 1'b0;
   logic        rst       [2];
   logic        in_valid  [2];
   logic        in_ready  [2];
   logic [15:0] a         [2];
   logic [15:0] b         [2];
   logic        cin       [2];
   logic        sub       [2];
   logic        out_valid [2];
   logic        out_ready [2];
   logic [15:0] sum       [2];
   logic        cout      [2];
   logic        ovf       [2];

   int errs   = 0;
   int checks = 0;

   always #5 clk = ~clk;

   add_serial_n #(.WIDTH(16), .DIGIT(4)) u_dut4 (
      .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .a(a[0]), .b(b[0]), .cin(cin[0]), .sub(sub[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .sum(sum[0]), .cout(cout[0]), .ovf(ovf[0])
   );

   add_serial_n #(.WIDTH(16), .DIGIT(16)) u_dut16 (
      .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .a(a[1]), .b(b[1]), .cin(cin[1]), .sub(sub[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .sum(sum[1]), .cout(cout[1]), .ovf(ovf[1])
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Integer-arithmetic reference: returns {ovf, cout, sum}
   function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                         input logic mc, input logic ms);
      int ua, ub, sa, sb, r, sr;
      logic c, o;
      ua = ma;
      ub = mb;
      sa = $signed(ma);
      sb = $signed(mb);
      if (ms) begin
         r  = ua - ub;
         c  = (ua >= ub);
         sr = sa - sb;
      end else begin
         r  = ua + ub + int'(mc);
         c  = (r > 65535);
         sr = sa + sb + int'(mc);
      end
      o = (sr > 32767) || (sr < -32768);
      return {o, c, r[15:0]};
   endfunction

   function automatic int steps_of(input int k);
      return (k == 0) ? 4 : 1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic accept(input int k, input logic [15:0] ta, input logic [15:0] tb_v,
                         input logic tc, input logic ts, input string tag);
      check({tag, ".in_ready"}, 32'(in_ready[k]), 32'd1);
      a[k] = ta; b[k] = tb_v; cin[k] = tc; sub[k] = ts;
      in_valid[k] = 1'b1;
      tick();
      in_valid[k] = 1'b0;
      a[k] = 16'($urandom); b[k] = 16'($urandom);
      cin[k] = 1'($urandom); sub[k] = 1'($urandom);
   endtask

   task automatic run_op(input int k, input logic [15:0] ta, input logic [15:0] tb_v,
                         input logic tc, input logic ts, input int hold, input string tag);
      logic [17:0] exp;
      int n;
      exp = model(ta, tb_v, tc, ts);
      accept(k, ta, tb_v, tc, ts, tag);
      n = 0;
      while (!out_valid[k] && n < 50) begin
         tick();
         n++;
      end
      check({tag, ".latency"}, 32'(n), 32'(steps_of(k)));
      check({tag, ".sum"}, 32'(sum[k]), 32'(exp[15:0]));
      check({tag, ".cout"}, 32'(cout[k]), 32'(exp[16]));
      check({tag, ".ovf"}, 32'(ovf[k]), 32'(exp[17]));
      for (int i = 0; i < hold; i++) begin
         in_valid[k] = 1'b1;
         a[k] = 16'($urandom); b[k] = 16'($urandom);
         tick();
         check({tag, ".hold_rdy"}, 32'(in_ready[k]), 32'd0);
         check({tag, ".hold_vld"}, 32'(out_valid[k]), 32'd1);
         check({tag, ".hold_res"}, 32'({ovf[k], cout[k], sum[k]}), 32'(exp));
      end
      in_valid[k] = 1'b0;
      out_ready[k] = 1'b1;
      tick();
      out_ready[k] = 1'b0;
      check({tag, ".drop_vld"}, 32'(out_valid[k]), 32'd0);
      check({tag, ".idle_rdy"}, 32'(in_ready[k]), 32'd1);
      check({tag, ".kept_res"}, 32'({ovf[k], cout[k], sum[k]}), 32'(exp));
   endtask

   task automatic suite(input int k);
      string p;
      p = (k == 0) ? "d4" : "d16";
      run_op(k, 16'h1234, 16'h4321, 1'b0, 1'b0, 0, {p, ".basic"});
      run_op(k, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, {p, ".carry"});
      run_op(k, 16'h0000, 16'h0000, 1'b1, 1'b0, 0, {p, ".cin"});
      run_op(k, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, {p, ".ovf_add"});
      run_op(k, 16'h8000, 16'h0001, 1'b0, 1'b1, 0, {p, ".ovf_sub"});
      run_op(k, 16'h0005, 16'h0007, 1'b1, 1'b1, 0, {p, ".borrow"});
      run_op(k, 16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 3, {p, ".backpr"});
      for (int i = 0; i < 20; i++)
         run_op(k, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                int'($urandom_range(0, 3)), {p, ".rand"});
      run_op(k, 16'h1111, 16'h2222, 1'b0, 1'b0, 0, {p, ".pre_rst"});
      // Abort on the second edge after acceptance
      accept(k, 16'h0F0F, 16'h0101, 1'b0, 1'b0, {p, ".abort"});
      tick();
      rst[k] = 1'b1;
      tick();
      rst[k] = 1'b0;
      check({p, ".rst_rdy"}, 32'(in_ready[k]), 32'd1);
      check({p, ".rst_vld"}, 32'(out_valid[k]), 32'd0);
      check({p, ".rst_res"}, 32'({ovf[k], cout[k], sum[k]}), 32'd0);
      run_op(k, 16'h0003, 16'h0004, 1'b0, 1'b0, 0, {p, ".after_rst"});
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         rst[k] = 1'b1; in_valid[k] = 1'b0; out_ready[k] = 1'b0;
         a[k] = '0; b[k] = '0; cin[k] = 1'b0; sub[k] = 1'b0;
      end
      repeat (2) tick();
      for (int k = 0; k < 2; k++) begin
         rst[k] = 1'b0;
         check("reset.in_ready", 32'(in_ready[k]), 32'd1);
         check("reset.out_valid", 32'(out_valid[k]), 32'd0);
         check("reset.result", 32'({ovf[k], cout[k], sum[k]}), 32'd0);
      end
      suite(0);
      suite(1);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/add_serial_n.md
Name: add_serial_n

Overview:
- Parametrised multi-cycle adder/subtractor. Processes a WIDTH-bit operand pair DIGIT bits per clock through a chain of full-adder cells.
- The carry is registered between digits.
- Successor to the fixed 4-bit ripple adder. Adds width/digit generalisation, a subtract mode, an overflow flag and a valid/ready handshake.
- Used wherever area matters more than single-cycle latency.

Parameters:
- WIDTH, 16, operand and result width in bits; must be >= 1.
- DIGIT, 4, bits added per cycle; WIDTH % DIGIT == 0 is checked at elaboration (fatal otherwise).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and mode are valid.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  operand A (unsigned or two's complement).
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; used in add mode only.
- sub  input  1  0 = A+B+cin, 1 = A-B.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry-out of the MSB; in sub mode 1 = no borrow.
- ovf  output  1  signed overflow.

Behaviour:
- Interface: one clock, clk. Synchronous active-high reset, rst.
- Reset values: state = IDLE; in_ready = 1; out_valid = 0; sum = 0; cout = 0; ovf = 0; internal operand, carry and step counter registers = 0.
- STEPS = WIDTH/DIGIT.
- State machine: IDLE -> RUN -> DONE -> IDLE.
  - IDLE:
    - in_ready = 1.
    - On in_valid at the edge, capture a, b XOR {WIDTH{sub}}, and carry0 = sub ? 1 : cin.
    - Clear the step counter and go to RUN.
  - RUN:
    - in_ready = 0.
    - Each edge adds digit[step] of A and B' plus the registered carry, writes DIGIT result bits into sum, updates the carry and increments step.
    - Digit order is LSB first.
    - On the edge processing step STEPS-1: register cout = final carry and ovf = (A[MSB] == B'[MSB]) && (sum[MSB] != A[MSB]), then go to DONE.
  - DONE:
    - out_valid = 1.
    - sum, cout and ovf are held stable while out_ready = 0.
    - On out_ready, go to IDLE; out_valid drops the next cycle.
    - sum, cout and ovf keep their last value until the next operation overwrites them.
- Latency: the acceptance edge is followed by STEPS edges; out_valid is high after the STEPS-th edge. Minimum initiation interval is STEPS+2 cycles.
- Inputs are sampled only on the acceptance edge. Changes to a, b, cin or sub afterwards have no effect.
- in_valid while not in IDLE is ignored; there is no queueing.
- DIGIT == WIDTH: STEPS = 1, single RUN cycle, same handshake.
- WIDTH == 1: ovf = cout XOR carry into the MSB (same formula holds).
- Reset mid-operation (RUN or DONE) aborts the operation and restores all reset values on that edge. No partial result is ever flagged valid.
- Reset has priority over every other event on the same edge.
- sum is unspecified-but-stable while in RUN. Verification checks it only when out_valid = 1.

Decomposition:
- Shared package add_pkg:
  - state encoding (IDLE, RUN, DONE);
  - function steps(WIDTH, DIGIT);
  - a localparam for the counter width, $clog2(STEPS) with a minimum of 1.
- Sub-module add_digit:
  - combinational DIGIT-bit ripple of full-adder cells;
  - inputs: a_d, b_d, c_in;
  - outputs: s_d, c_out, c_msb_in (carry into the top bit, for ovf);
  - instantiated once in add_serial_n.

Test Plan:
- Basic add (WIDTH=16, DIGIT=4): a=0x1234, b=0x4321, sub=0, cin=0 -> sum=0x5555, cout=0, ovf=0; out_valid rises exactly 4 edges after acceptance.
- Carry chain: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Also a=0x0000, b=0x0000, cin=1 -> sum=0x0001.
- Signed overflow: a=0x7FFF, b=0x0001 add -> sum=0x8000, ovf=1, cout=0. Sub a=0x8000, b=0x0001 -> sum=0x7FFF, ovf=1, cout=1.
- Subtract with borrow: a=0x0005, b=0x0007, sub=1, cin=1 (must be ignored) -> sum=0xFFFE, cout=0, ovf=0.
- Backpressure and ignored input:
  - Stimulus: hold out_ready=0 for 3 cycles in DONE and pulse in_valid with new operands.
  - Required: sum, cout and ovf remain stable; in_ready=0; the new operands are not taken. After out_ready=1, in_ready=1 on the following cycle.
- Reset and degenerate config:
  - Stimulus: assert rst on the 2nd RUN edge.
  - Required: next cycle in_ready=1, out_valid=0, sum=0. A fresh 0x0003+0x0004 then completes with sum=0x0007.
  - Repeat the suite with DIGIT=16 -> out_valid 1 edge after acceptance.
